// File: rtl/bs_pkg.sv
// bs_pkg: shared encodings, 44.20 fixed-point constants and datapath latency budget for the BS Monte-Carlo run controller.
package bs_pkg;
  localparam logic [3:0] CMD_RUN     = 4'd1;
  localparam logic [3:0] CMD_ACK     = 4'd2;
  localparam logic [3:0] CMD_ABORT   = 4'd3;
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RUNNING  = 4'd1;
  localparam logic [3:0] ST_DRAIN    = 4'd2;
  localparam logic [3:0] ST_COMPLETE = 4'd3;
  localparam int FX_INT_W  = 44;
  localparam int FX_FRAC_W = 20;
  localparam logic [63:0] FX_ONE = 64'd1 << FX_FRAC_W;
  // fp datapath stage latencies: exp, multiply, add, square
  localparam int LAT_EXP = 20;
  localparam int LAT_MUL = 5;
  localparam int LAT_ADD = 8;
  localparam int LAT_SQ  = 12;
  localparam int BS_PIPE_LAT = LAT_EXP + LAT_MUL + LAT_ADD + LAT_SQ;
endpackage

// File: rtl/bs_valid_pipe.sv
// bs_valid_pipe: valid delay line; o_tap marks a result DEPTH cycles after issue, o_inflight excludes the path retiring this cycle.
module bs_valid_pipe #(
  parameter int DEPTH = 45,
  parameter int CW    = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          o_tap,
  output logic [CW-1:0] o_inflight
);
  logic [DEPTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  assign o_tap      = r_sr[DEPTH-1];
  assign o_inflight = r_cnt - CW'(o_tap) + CW'(i_valid);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= (r_sr << 1) | DEPTH'(i_valid);
      r_cnt <= r_cnt + CW'(i_valid) - CW'(o_tap);
    end
  end
endmodule

// File: rtl/bs_mc_accum_ctrl.sv
// bs_mc_accum_ctrl: count-exact, drain-aware run controller and saturating payoff accumulator.
// Define BS_ANTITHETIC_EN to issue each sample twice (second copy sign-flipped).
module bs_mc_accum_ctrl
  import bs_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int PIPE_LAT = BS_PIPE_LAT,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic [CNT_W-1:0]  cfg_npaths,
  input  logic              grn_valid,
  input  logic [DATA_W-1:0] grn_data,
  output logic              grn_ready,
  output logic [DATA_W-1:0] dp_din,
  output logic              dp_issue,
  input  logic [ACC_W-1:0]  dp_payoff,
  input  logic [ACC_W-1:0]  dp_payoff_sq,
  output logic [3:0]        status,
  output logic [ACC_W-1:0]  sum,
  output logic [ACC_W-1:0]  sum_sq,
  output logic [CNT_W-1:0]  paths_done,
  output logic              ovf
);
  localparam int IFW = $clog2(PIPE_LAT + 2);
  logic [3:0]        r_status;
  logic [CNT_W-1:0]  r_npaths, r_issued, r_done;
  logic [DATA_W-1:0] r_din;
  logic              r_issue, r_ovf;
  logic [ACC_W-1:0]  r_sum, r_sum_sq;
  logic              w_abort, w_accept, w_mir, w_busy, w_issue, w_tap;
  logic [CNT_W-1:0]  w_iss_nxt;
  logic [IFW-1:0]    w_inflight;
  logic [ACC_W:0]    w_sum_add, w_sq_add;
  assign w_abort   = cmd == CMD_ABORT;
  assign grn_ready = (r_status == ST_RUNNING) && (r_issued != r_npaths) && !w_busy && !w_abort;
  assign w_accept  = grn_valid && grn_ready;
  assign w_issue   = w_accept || w_mir;
  assign w_iss_nxt = r_issued + CNT_W'(w_issue);
  assign w_sum_add = {1'b0, r_sum} + {1'b0, dp_payoff};
  assign w_sq_add  = {1'b0, r_sum_sq} + {1'b0, dp_payoff_sq};
`ifdef BS_ANTITHETIC_EN
  logic r_mirror;
  assign w_busy = r_mirror;
  assign w_mir  = (r_status == ST_RUNNING) && r_mirror && !w_abort;
  // mirror is owed only if a path remains after the original
  always_ff @(posedge clk) r_mirror <= !reset && w_accept && (r_issued + CNT_W'(1) != r_npaths);
`else
  assign w_busy = 1'b0;
  assign w_mir  = 1'b0;
`endif
  bs_valid_pipe #(.DEPTH(PIPE_LAT), .CW(IFW)) u_vpipe (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (r_issue),
    .o_tap     (w_tap),
    .o_inflight(w_inflight)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= ST_IDLE;
      r_npaths <= '0;
      r_issued <= '0;
      r_done   <= '0;
      r_din    <= '0;
      r_issue  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sum    <= '0;
      r_sum_sq <= '0;
    end else begin
      r_issue  <= w_issue;
      r_issued <= w_iss_nxt;
      if (w_accept) r_din <= grn_data;
      else if (w_mir) r_din <= {~r_din[DATA_W-1], r_din[DATA_W-2:0]};
      if (w_tap && r_status != ST_IDLE) begin
        r_sum    <= w_sum_add[ACC_W] ? '1 : w_sum_add[ACC_W-1:0];
        r_sum_sq <= w_sq_add[ACC_W] ? '1 : w_sq_add[ACC_W-1:0];
        r_done   <= r_done + CNT_W'(1);
        r_ovf    <= r_ovf | w_sum_add[ACC_W] | w_sq_add[ACC_W];
      end
      case (r_status)
        ST_IDLE: if (cmd == CMD_RUN) begin
          r_npaths <= cfg_npaths;
          r_issued <= '0;
          r_done   <= '0;
          r_sum    <= '0;
          r_sum_sq <= '0;
          r_ovf    <= 1'b0;
          r_status <= (cfg_npaths == '0) ? ST_COMPLETE : ST_RUNNING;
        end
        ST_RUNNING:  if (w_abort || w_iss_nxt == r_npaths) r_status <= ST_DRAIN;
        ST_DRAIN:    if (w_inflight == '0) r_status <= ST_COMPLETE;
        ST_COMPLETE: if (cmd == CMD_ACK) r_status <= ST_IDLE;
        default:     r_status <= ST_IDLE;
      endcase
    end
  end
  assign status     = r_status;
  assign dp_din     = r_din;
  assign dp_issue   = r_issue;
  assign sum        = r_sum;
  assign sum_sq     = r_sum_sq;
  assign paths_done = r_done;
  assign ovf        = r_ovf;
endmodule
